// File: rtl/rle_bit_unpacker_if.sv
// Valid/ready stream bundle with a last-word qualifier.
// The master drives data/valid/last; the slave drives ready.
interface rle_bit_unpacker_if #(
    parameter int W = 16
);
    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/rle_bit_unpacker.sv
// Run-length decoder: header bit + run lengths -> packed DATA_W-bit words.
// Define RLE_UNPACK_WCOUNT_EN to add the saturating word_count output.
module rle_bit_unpacker #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    rle_bit_unpacker_if.slave  in_if,
    rle_bit_unpacker_if.master out_if,
    output logic busy,
    output logic done
`ifdef RLE_UNPACK_WCOUNT_EN
    ,
    output logic [15:0] word_count
`endif
);
    localparam int IW = $clog2(DATA_W + 1);
    localparam int MW = ((CNT_W > IW) ? CNT_W : IW) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FILL,
        S_EMIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     w_idx_nx;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  w_rem_nx;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_nx;
    logic              r_bit;
    logic              w_bit_nx;
    logic              r_last_run;
    logic              w_last_run_nx;
    logic              r_out_last;
    logic              w_out_last_nx;
    logic              r_done;
    logic              w_done_nx;

    logic [MW-1:0]     w_space;
    logic [MW-1:0]     w_n;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_fill;
    logic [CNT_W-1:0]  w_rem_dec;
    logic [IW-1:0]     w_idx_inc;
    logic              w_run_end;
    logic              w_full;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // One FILL cycle places as many copies of the run bit as fit in the word
    assign w_space   = MW'(DATA_W) - MW'(r_idx);
    assign w_n       = (MW'(r_rem) < w_space) ? MW'(r_rem) : w_space;
    assign w_mask    = (w_n >= MW'(DATA_W)) ? '1
                     : ((DATA_W'(1) << w_n) - DATA_W'(1));
    assign w_fill    = w_mask << r_idx;
    assign w_rem_dec = r_rem - CNT_W'(w_n);
    assign w_idx_inc = r_idx + IW'(w_n);
    assign w_run_end = (w_rem_dec == '0);
    assign w_full    = (w_idx_inc == IW'(DATA_W));

    assign w_in_xfer  = in_if.valid & in_if.ready;
    assign w_out_xfer = out_if.valid & out_if.ready;

    assign in_if.ready  = (r_state == S_HDR) || (r_state == S_LOAD);
    assign out_if.valid = (r_state == S_EMIT);
    assign out_if.data  = r_word;
    assign out_if.last  = r_out_last;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;

    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_rem_nx      = r_rem;
        w_word_nx     = r_word;
        w_bit_nx      = r_bit;
        w_last_run_nx = r_last_run;
        w_out_last_nx = r_out_last;
        w_done_nx     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx    = S_HDR;
                    w_idx_nx      = '0;
                    w_word_nx     = '0;
                    w_out_last_nx = 1'b0;
                end
            end
            S_HDR: begin
                if (w_in_xfer) begin
                    w_bit_nx = in_if.data[0];
                    if (in_if.last) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_in_xfer) begin
                    w_rem_nx      = in_if.data;
                    w_last_run_nx = in_if.last;
                    w_state_nx    = S_FILL;
                end
            end
            S_FILL: begin
                w_rem_nx  = w_rem_dec;
                w_idx_nx  = w_idx_inc;
                w_word_nx = r_word | (r_bit ? w_fill : '0);
                if (w_run_end) begin
                    w_bit_nx = ~r_bit;
                end
                if (w_full) begin
                    w_state_nx    = S_EMIT;
                    w_out_last_nx = w_run_end & r_last_run;
                end else if (w_run_end) begin
                    if (!r_last_run) begin
                        w_state_nx = S_LOAD;
                    end else if (w_idx_inc != '0) begin
                        // final partial word, upper bits stay zero
                        w_state_nx    = S_EMIT;
                        w_out_last_nx = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            S_EMIT: begin
                if (w_out_xfer) begin
                    w_idx_nx      = '0;
                    w_word_nx     = '0;
                    w_out_last_nx = 1'b0;
                    if (r_out_last) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end else if (r_rem != '0) begin
                        w_state_nx = S_FILL;
                    end else begin
                        w_state_nx = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_rem      <= '0;
            r_word     <= '0;
            r_bit      <= 1'b0;
            r_last_run <= 1'b0;
            r_out_last <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_rem      <= w_rem_nx;
            r_word     <= w_word_nx;
            r_bit      <= w_bit_nx;
            r_last_run <= w_last_run_nx;
            r_out_last <= w_out_last_nx;
            r_done     <= w_done_nx;
        end
    end

`ifdef RLE_UNPACK_WCOUNT_EN
    logic [15:0] r_wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_wcnt <= '0;
        end else if (w_out_xfer && (r_wcnt != 16'hFFFF)) begin
            r_wcnt <= r_wcnt + 16'd1;
        end
    end

    assign word_count = r_wcnt;
`endif

endmodule

// File: tb/tb_rle_bit_unpacker.sv
// Directed and random frames checked against a bit-stream reference model.
// Define RLE_UNPACK_WCOUNT_EN to also check word_count.
module tb_rle_bit_unpacker;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef RLE_UNPACK_WCOUNT_EN
    logic [15:0] word_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    int                q_runs[$];
    logic [DATA_W-1:0] exp_w[$];
    logic              exp_l[$];
    logic [DATA_W-1:0] got_w[$];

    rle_bit_unpacker_if #(.W(CNT_W))  in_if ();
    rle_bit_unpacker_if #(.W(DATA_W)) out_if ();

    rle_bit_unpacker #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_if (in_if),
        .out_if(out_if),
        .busy  (busy),
        .done  (done)
`ifdef RLE_UNPACK_WCOUNT_EN
        ,
        .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expand runs into a flat bit list, then slice into zero-padded words
    function automatic void model(input logic hdr, output int total);
        logic              b;
        logic              bits[$];
        logic [DATA_W-1:0] w;
        int                nw;
        exp_w.delete();
        exp_l.delete();
        b = hdr;
        foreach (q_runs[i]) begin
            for (int r = 0; r < q_runs[i]; r++) bits.push_back(b);
            b = ~b;
        end
        total = bits.size();
        nw = (total + DATA_W - 1) / DATA_W;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            for (int j = 0; j < DATA_W; j++)
                if (wi * DATA_W + j < total) w[j] = bits[wi * DATA_W + j];
            exp_w.push_back(w);
            // trailing empty runs after an exactly full word leave it unflagged
            exp_l.push_back((wi == nw - 1) &&
                !((total % DATA_W == 0) && (q_runs[q_runs.size() - 1] == 0)));
        end
    endfunction

    // mode 0: sink always ready; 1: random gaps/backpressure/start noise;
    // 2: first output word stalled for five cycles
    task automatic run_frame(input logic hdr, input int mode,
                             input string name);
        logic [CNT_W-1:0]  iw[$];
        logic [DATA_W-1:0] hd;
        logic              hl;
        logic              rdy;
        bit                hold;
        bit                fin;
        int                total;
        int                nin;
        int                k;
        int                stall;
        int                budget;
        model(hdr, total);
        got_w.delete();
        if (mode == 1)
            iw.push_back({CNT_W'($urandom) >> 1, hdr});
        else
            iw.push_back(CNT_W'(hdr));
        foreach (q_runs[i]) iw.push_back(CNT_W'(q_runs[i]));
        nin    = iw.size();
        budget = 100 + 3 * total + 4 * nin;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " busy_after_start"}, busy, 1);
`ifdef RLE_UNPACK_WCOUNT_EN
        chk({name, " wcount_cleared"}, word_count, 0);
`endif
        k     = 0;
        stall = 0;
        hold  = 0;
        fin   = 0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            if (hold) begin
                chk({name, " hold_valid"}, out_if.valid, 1);
                chk({name, " hold_data"}, out_if.data, hd);
                chk({name, " hold_last"}, out_if.last, hl);
            end
            if (done) begin
                fin = 1;
                start = 1'b0;
                in_if.valid = 1'b0;
                out_if.ready = 1'b0;
                chk({name, " done_busy"}, busy, 0);
                chk({name, " done_valid"}, out_if.valid, 0);
                chk({name, " words_left"}, exp_w.size(), 0);
                chk({name, " inputs_used"}, k, nin);
            end else begin
                if (out_if.valid)
                    chk({name, " ready_under_valid"}, in_if.ready, 0);
                in_if.valid = (k < nin) &&
                              (mode != 1 || $urandom_range(0, 3) != 0);
                in_if.data  = (k < nin) ? iw[k] : CNT_W'($urandom);
                in_if.last  = (k == nin - 1);
                if (mode == 1) begin
                    rdy = ($urandom_range(0, 2) != 0);
                end else if (mode == 2 && out_if.valid && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = 1'b1;
                end
                out_if.ready = rdy;
                start = (mode == 1) && ($urandom_range(0, 3) == 0);
                if (in_if.valid && in_if.ready) k++;
                hold = 0;
                if (out_if.valid) begin
                    if (rdy) begin
                        got_w.push_back(out_if.data);
                        if (exp_w.size() > 0) begin
                            chk({name, " data"}, out_if.data, exp_w[0]);
                            chk({name, " last"}, out_if.last, exp_l[0]);
                            void'(exp_w.pop_front());
                            void'(exp_l.pop_front());
                        end else begin
                            chk({name, " extra_word"}, got_w.size(), 0);
                        end
                    end else begin
                        hold = 1;
                        hd   = out_if.data;
                        hl   = out_if.last;
                    end
                end
                @(negedge clk);
            end
        end
        chk({name, " finished_in_budget"}, fin, 1);
        start = 1'b0;
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        @(negedge clk);
        chk({name, " done_single_pulse"}, done, 0);
        chk({name, " idle_valid"}, out_if.valid, 0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.last   = 1'b0;
        out_if.ready = 1'b0;
        #12;
        chk("reset out_valid", out_if.valid, 0);
        chk("reset out_data", out_if.data, 0);
        chk("reset out_last", out_if.last, 0);
        chk("reset in_ready", in_if.ready, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        @(negedge clk);
        rst = 1'b1;

        q_runs = '{3, 13};
        run_frame(1'b1, 0, "r033");
        chk("r033 word", got_w[0], 16'h0007);
        chk("r033 count", got_w.size(), 1);

        q_runs = '{20, 12};
        run_frame(1'b0, 0, "r034");
        chk("r034 word0", got_w[0], 16'h0000);
        chk("r034 word1", got_w[1], 16'hFFF0);
`ifdef RLE_UNPACK_WCOUNT_EN
        chk("r034 wcount", word_count, 2);
`endif

        q_runs = '{0, 4};
        run_frame(1'b1, 0, "r035");
        chk("r035 word", got_w[0], 16'h0000);
        chk("r035 count", got_w.size(), 1);

        q_runs = '{20, 12};
        run_frame(1'b0, 2, "r036");
        chk("r036 word1", got_w[1], 16'hFFF0);

        q_runs.delete();
        run_frame(1'b1, 0, "empty");
        chk("empty count", got_w.size(), 0);

        q_runs = '{16, 0};
        run_frame(1'b1, 0, "full_then_zero");
        chk("full_then_zero word", got_w[0], 16'hFFFF);

        // reset while the first run is being written
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        in_if.valid = 1'b1;
        in_if.data  = 16'd0;
        in_if.last  = 1'b0;
        @(negedge clk);
        in_if.data = 16'd20;
        @(negedge clk);
        in_if.valid = 1'b0;
        chk("r037 busy_in_fill", busy, 1);
        rst = 1'b0;
        #1;
        chk("r037 busy", busy, 0);
        chk("r037 in_ready", in_if.ready, 0);
        chk("r037 out_valid", out_if.valid, 0);
        chk("r037 out_data", out_if.data, 0);
        chk("r037 out_last", out_if.last, 0);
        chk("r037 done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst         = 1'b1;
        in_if.valid = 1'b1;
        in_if.data  = 16'd1;
        repeat (4) begin
            @(negedge clk);
            chk("r037 stays_idle", busy, 0);
            chk("r037 no_ready", in_if.ready, 0);
        end
        in_if.valid = 1'b0;
        q_runs = '{3, 13};
        run_frame(1'b1, 0, "r037_rerun");
        chk("r037 rerun word", got_w[0], 16'h0007);

        q_runs = '{65535, 1};
        run_frame(1'b0, 0, "max_run");
        chk("max_run count", got_w.size(), 4096);

        for (int f = 0; f < 30; f++) begin
            q_runs.delete();
            for (int r = $urandom_range(0, 8); r > 0; r--) begin
                if ($urandom_range(0, 7) == 0)
                    q_runs.push_back(0);
                else
                    q_runs.push_back($urandom_range(1, 40));
            end
            run_frame(1'($urandom_range(0, 1)), 1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rle_bit_unpacker.md
RLE_BIT_UNPACKER -- requirements
Module: rle_bit_unpacker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning output word width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning run-length word width in bits (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  begin a frame; sampled only in IDLE.
REQ-006 in_data  input  CNT_W  header word (bit 0 = first bit value) or run length.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_last  input  1  qualifies in_data as the final word of the frame.
REQ-009 in_ready  output  1  block accepts in_data; transfer = in_valid & in_ready.
REQ-010 out_data  output  DATA_W  decoded bits, LSB = earliest bit.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts; transfer = out_valid & out_ready.
REQ-013 out_last  output  1  qualifies the final word of the frame.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 done  output  1  one-cycle pulse at frame end.

Function
REQ-016 SHALL implement states IDLE, HDR, LOAD, FILL, EMIT.
REQ-017 IDLE: in_ready=0; start=1 -> HDR, clear fill index and word register; start outside IDLE ignored.
REQ-018 HDR: in_ready=1; on transfer latch cur_bit=in_data[0]; in_last=0 -> LOAD; in_last=1 -> IDLE with done pulse, no output (empty frame).
REQ-019 LOAD: in_ready=1; on transfer latch remaining=in_data, last_run=in_last -> FILL.
REQ-020 FILL: each cycle write n=min(remaining, DATA_W-idx) copies of cur_bit into bits idx..idx+n-1; remaining-=n; idx+=n; in_ready=0.
REQ-021 Run ends (remaining reaches 0, including zero-length run) SHALL toggle cur_bit in that same cycle.
REQ-022 idx reaches DATA_W -> EMIT; out_last=1 if the run ended this cycle and last_run=1.
REQ-023 Run ends with idx<DATA_W: last_run=0 -> LOAD; last_run=1 and idx>0 -> EMIT with out_last=1, bits idx..DATA_W-1 zero; last_run=1 and idx=0 -> IDLE, done pulse, no word.
REQ-024 out_valid SHALL assert the cycle after the FILL cycle that completed the word; out_data/out_last held stable until transfer.
REQ-025 EMIT transfer: clear idx and word; out_last=1 -> IDLE with done pulse same edge; else remaining>0 -> FILL; else -> LOAD.
REQ-026 in_ready SHALL be 0 while out_valid=1 (no input accepted under backpressure).
REQ-027 remaining SHALL be CNT_W bits; run length up to 2^CNT_W-1 spans multiple words with no lost bits.
REQ-028 done SHALL be a single-cycle pulse; out_valid and done never high in the same cycle.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE; out_data=0, out_valid=0, out_last=0, in_ready=0, busy=0, done=0; idx, remaining, cur_bit, last_run cleared.
REQ-030 Reset mid-frame SHALL discard partial word and pending output; first activity after release requires start.

Configuration
REQ-031 With RLE_UNPACK_WCOUNT_EN defined, SHALL add output word_count[15:0]: cleared on accepted start, +1 per out transfer, saturating at 0xFFFF, reset 0.
REQ-032 Without RLE_UNPACK_WCOUNT_EN, port word_count and its logic SHALL be absent; all other behaviour identical.

Verification (DATA_W=16, CNT_W=16)
REQ-033 start; header 0x0001; runs 3, 13(last) -> one word out_data=0x0007, out_last=1, then done pulse.
REQ-034 start; header 0x0000; runs 20, 12(last) -> 0x0000 (out_last=0) then 0xFFF0 (out_last=1), done.
REQ-035 start; header 0x0001; runs 0, 4(last) -> zero run toggles to 0; one word 0x0000, out_last=1, done.
REQ-036 REQ-034 with out_ready=0 for 5 cycles on first word -> out_data stable 0x0000, in_ready=0 throughout, identical final output.
REQ-037 rst=0 during FILL of REQ-034 -> all outputs 0 immediately; rerun REQ-033 after release -> 0x0007 correct.
REQ-038 With RLE_UNPACK_WCOUNT_EN, after REQ-034 word_count=2; after next start word_count=0.
